imm_shifter_pipe: RTL and testbench

//  Pipelined operand-2 generator. Successor to the combinational immediate extender.

---
 rtl/imm_shifter_pipe_pkg.sv | 63 ++++++
 rtl/imm_shift_core.sv | 53 +++++
 rtl/imm_shifter_pipe.sv | 111 +++++++++++
 tb/tb_imm_shifter_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_shifter_pipe_pkg.sv
// Shared definitions for the pipelined operand-2 generator: mode codes, shift
// types, the decoded-operation record and the decode function.
package imm_shifter_pipe_pkg;

  localparam logic [2:0] IMM_ROT8 = 3'b000;
  localparam logic [2:0] IMM_LS12 = 3'b001;
  localparam logic [2:0] IMM_BR24 = 3'b010;
  localparam logic [2:0] IMM_RSH  = 3'b011;
  localparam logic [2:0] IMM_HW8  = 3'b100;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } sh_type_e;

  // Everything the final stage needs; modes that bypass the shifter carry
  // their finished value in data with use_core clear.
  typedef struct packed {
    logic        use_core;
    logic [31:0] data;
    logic [5:0]  amount;
    sh_type_e    sh_type;
    logic        cin;
    logic        err;
  } op_t;

  function automatic op_t decode_op(input logic [31:0] instr,
                                    input logic [2:0]  src,
                                    input logic [31:0] rm,
                                    input logic        cin,
                                    input int unsigned br_shift);
    op_t op;
    op         = '0;
    op.sh_type = SH_LSL;
    op.cin     = cin;
    case (src)
      IMM_ROT8: begin
        // A zero rotate is issued as LSL#0 so the core treats it as a
        // pass-through rather than RRX.
        op.use_core = 1'b1;
        op.data     = {24'b0, instr[7:0]};
        op.amount   = {1'b0, instr[11:8], 1'b0};
        op.sh_type  = (instr[11:8] == 4'd0) ? SH_LSL : SH_ROR;
      end
      IMM_LS12: op.data = {20'b0, instr[11:0]};
      IMM_BR24: op.data = {{8{instr[23]}}, instr[23:0]} << br_shift;
      IMM_RSH: begin
        op.use_core = 1'b1;
        op.data     = rm;
        op.sh_type  = sh_type_e'(instr[6:5]);
        op.amount   = {1'b0, instr[11:7]};
        if (instr[11:7] == 5'd0 && (op.sh_type == SH_LSR || op.sh_type == SH_ASR))
          op.amount = 6'd32;
      end
      IMM_HW8:  op.data = {24'b0, instr[11:8], instr[3:0]};
      default:  op.err  = 1'b1;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_shift_core.sv
// Combinational 32-bit shifter/rotator. Amount 0 means pass-through for
// LSL/LSR/ASR and RRX for ROR. Carry logic exists only with SHIFTER_CARRY_EN.
module imm_shift_core
  import imm_shifter_pipe_pkg::*;
(
  input  logic [31:0] data,
  input  logic [5:0]  amount,
  input  sh_type_e    sh_type,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic        carry_out
);

  logic [31:0] ror_r;

  assign ror_r = (data >> amount[4:0]) | (data << (6'd32 - {1'b0, amount[4:0]}));

`ifdef SHIFTER_CARRY_EN
  // Shifting with carry_in appended on the outgoing side leaves the last bit
  // shifted out (or carry_in for a zero shift) in the extra position.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path leaves a latch behind.
    result    = data;
    carry_out = carry_in;
    case (sh_type)
      SH_LSL: {carry_out, result} = {carry_in, data} << amount;
      SH_LSR: {result, carry_out} = {data, carry_in} >> amount;
      SH_ASR: {result, carry_out} = $signed({data, carry_in}) >>> amount;
      default: begin
        if (amount == 6'd0) begin
          {result, carry_out} = {carry_in, data};
        end else begin
          result    = ror_r;
          carry_out = ror_r[31];
        end
      end
    endcase
  end
`else
  always_comb begin
    result    = data;
    carry_out = 1'b0;
    case (sh_type)
      SH_LSL:  result = data << amount;
      SH_LSR:  result = data >> amount;
      SH_ASR:  result = $signed(data) >>> amount;
      default: result = (amount == 6'd0) ? {carry_in, data[31:1]} : ror_r;
    endcase
  end
`endif

endmodule

// File: rtl/imm_shifter_pipe.sv
// Pipelined operand-2 generator with valid/ready handshake and sideband tag.
// Optional macro SHIFTER_CARRY_EN enables the shifter carry output.
module imm_shifter_pipe
  import imm_shifter_pipe_pkg::*;
#(
  parameter int PIPE_STAGES = 2,  // 1 or 2
  parameter int BR_SHIFT    = 2,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [2:0]       imm_src,
  input  logic [31:0]      rm_data,
  input  logic             carry_in,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             carry_out,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  op_t              dec_op;
  op_t              core_op;
  logic             core_valid;
  logic [TAG_W-1:0] core_tag;
  logic [31:0]      core_result;
  logic             core_carry;
  logic [31:0]      res_data;
  logic             res_carry;
  logic             out_open;
  logic             out_load;

  assign dec_op   = decode_op(instruction, imm_src, rm_data, carry_in, BR_SHIFT);
  assign out_open = !out_valid || out_ready;
  assign out_load = core_valid && out_open;

  if (PIPE_STAGES == 2) begin : g_two
    logic             s1_valid;
    logic             s1_advance;
    op_t              s1_op;
    logic [TAG_W-1:0] s1_tag;

    assign s1_advance = s1_valid && out_open;
    assign in_ready   = !s1_valid || s1_advance;

    always_ff @(posedge clk) begin
      if (rst)           s1_valid <= 1'b0;
      else if (in_ready) s1_valid <= in_valid;
    end

    // NOTE: payload registers carry no reset; s1_valid alone says whether
    // they hold anything meaningful.
    always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
        s1_op  <= dec_op;
        s1_tag <= in_tag;
      end
    end

    assign core_valid = s1_valid;
    assign core_op    = s1_op;
    assign core_tag   = s1_tag;
  end else begin : g_one
    assign in_ready   = out_open;
    assign core_valid = in_valid;
    assign core_op    = dec_op;
    assign core_tag   = in_tag;
  end

  imm_shift_core u_core (
    .data      (core_op.data),
    .amount    (core_op.amount),
    .sh_type   (core_op.sh_type),
    .carry_in  (core_op.cin),
    .result    (core_result),
    .carry_out (core_carry)
  );

  assign res_data = core_op.use_core ? core_result : core_op.data;

`ifdef SHIFTER_CARRY_EN
  assign res_carry = core_op.use_core ? core_carry : core_op.cin;
`else
  assign res_carry = core_carry;
`endif

  // Output register: holds its value while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      carry_out <= 1'b0;
      out_err   <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (out_open) out_valid <= core_valid;
      if (out_load) begin
        out_data  <= res_data;
        carry_out <= res_carry;
        out_err   <= core_op.err;
        out_tag   <= core_tag;
      end
    end
  end

endmodule

// File: tb/tb_imm_shifter_pipe.sv
// Self-checking bench: one DUT per legal pipeline depth (index 0 -> 1 stage,
// index 1 -> 2 stages), directed vector table plus stall/reset/stream sequences.
module tb_imm_shifter_pipe;
  import imm_shifter_pipe_pkg::*;

  localparam int TAG_W = 4;
`ifdef SHIFTER_CARRY_EN
  localparam bit CARRY_ON = 1'b1;
`else
  localparam bit CARRY_ON = 1'b0;
`endif

  typedef struct {
    logic [2:0]  src;
    logic [31:0] instr;
    logic [31:0] rm;
    logic        cin;
    logic [31:0] exp_data;
    logic        exp_c;
    logic        exp_err;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid  [2];
  logic             in_ready  [2];
  logic             out_valid [2];
  logic             out_ready [2];
  logic [31:0]      out_data  [2];
  logic             carry_out [2];
  logic             out_err   [2];
  logic [TAG_W-1:0] out_tag   [2];
  logic [31:0]      instruction;
  logic [2:0]       imm_src;
  logic [31:0]      rm_data;
  logic             carry_in;
  logic [TAG_W-1:0] in_tag;

  int tests_run    = 0;
  int tests_failed = 0;
  vec_t vecs [18];

  always #5 clk = ~clk;

  imm_shifter_pipe #(.PIPE_STAGES(1), .BR_SHIFT(2), .TAG_W(TAG_W)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .instruction(instruction), .imm_src(imm_src), .rm_data(rm_data),
    .carry_in(carry_in), .in_tag(in_tag), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .carry_out(carry_out[0]),
    .out_err(out_err[0]), .out_tag(out_tag[0])
  );

  imm_shifter_pipe #(.PIPE_STAGES(2), .BR_SHIFT(2), .TAG_W(TAG_W)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .instruction(instruction), .imm_src(imm_src), .rm_data(rm_data),
    .carry_in(carry_in), .in_tag(in_tag), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .carry_out(carry_out[1]),
    .out_err(out_err[1]), .out_tag(out_tag[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input int k, input int i);
    string p;
    p = $sformatf("v%0d_p%0d", i, k + 1);
    check({p, "_valid"}, 32'(out_valid[k]), 32'd1);
    check({p, "_data"},  out_data[k], vecs[i].exp_data);
    check({p, "_carry"}, 32'(carry_out[k]), 32'(vecs[i].exp_c & CARRY_ON));
    check({p, "_err"},   32'(out_err[k]), 32'(vecs[i].exp_err));
    check({p, "_tag"},   32'(out_tag[k]), 32'(i % 16));
  endtask

  // Hold out_ready low for 4 cycles while tags 1..3 are offered to one DUT.
  task automatic stall_test(input int k);
    int          nxt = 1;
    int          got = 0;
    bit          acc;
    logic [31:0] held = '0;
    string       p;
    p = $sformatf("stall_p%0d", k + 1);
    imm_src = IMM_LS12;
    in_valid[1-k]  = 1'b0;
    out_ready[1-k] = 1'b1;
    for (int cyc = 0; cyc < 24 && got < 3; cyc++) begin
      in_valid[k]  = (nxt <= 3);
      in_tag       = TAG_W'(nxt);
      instruction  = nxt * 32'h111;
      out_ready[k] = (cyc >= 4);
      @(negedge clk);
      if (cyc == 2) held = out_data[k];
      if (cyc == 3) begin
        check({p, "_held"},     32'(nxt - 1), 32'(k + 1));
        check({p, "_in_ready"}, 32'(in_ready[k]), 32'd0);
        check({p, "_valid"},    32'(out_valid[k]), 32'd1);
        check({p, "_stable"},   out_data[k], held);
        check({p, "_head"},     out_data[k], 32'h111);
      end
      if (out_valid[k] && out_ready[k]) begin
        check($sformatf("%s_tag%0d", p, got), 32'(out_tag[k]), 32'(got + 1));
        check($sformatf("%s_data%0d", p, got), out_data[k], (got + 1) * 32'h111);
        got++;
      end
      acc = in_valid[k] && in_ready[k];
      step();
      if (acc) nxt++;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    check({p, "_count"}, 32'(got), 32'd3);
    @(negedge clk);
    check({p, "_no_dup"}, 32'(out_valid[k]), 32'd0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stale [2];
    int cnt   [2];
    int first [2];
    int last  [2];
    int stall [2];

    //        src       instr          rm             cin   exp_data       c     err
    vecs[0]  = '{3'b000, 32'h0000_04FF, 32'h0,         1'b0, 32'hFF00_0000, 1'b1, 1'b0};
    vecs[1]  = '{3'b000, 32'h0000_00AB, 32'h0,         1'b1, 32'h0000_00AB, 1'b1, 1'b0};
    vecs[2]  = '{3'b000, 32'h0000_01C3, 32'h0,         1'b0, 32'hC000_0030, 1'b1, 1'b0};
    vecs[3]  = '{3'b001, 32'hABCD_E123, 32'h0,         1'b1, 32'h0000_0123, 1'b1, 1'b0};
    vecs[4]  = '{3'b010, 32'h00FF_FFFE, 32'h0,         1'b0, 32'hFFFF_FFF8, 1'b0, 1'b0};
    vecs[5]  = '{3'b010, 32'h0000_0010, 32'h0,         1'b1, 32'h0000_0040, 1'b1, 1'b0};
    vecs[6]  = '{3'b011, 32'h0000_0060, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 1'b0};
    vecs[7]  = '{3'b011, 32'h0000_0020, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8]  = '{3'b011, 32'h0000_0040, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[9]  = '{3'b011, 32'h0000_0000, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1'b0};
    vecs[10] = '{3'b011, 32'h0000_0200, 32'hF000_0001, 1'b0, 32'h0000_0010, 1'b1, 1'b0};
    vecs[11] = '{3'b011, 32'h0000_00A0, 32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1, 1'b0};
    vecs[12] = '{3'b011, 32'h0000_0440, 32'h8000_0080, 1'b0, 32'hFF80_0000, 1'b1, 1'b0};
    vecs[13] = '{3'b011, 32'h0000_0260, 32'h0000_000F, 1'b0, 32'hF000_0000, 1'b1, 1'b0};
    vecs[14] = '{3'b011, 32'h0000_0FA0, 32'h8000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    vecs[15] = '{3'b100, 32'h0000_0A05, 32'h0,         1'b1, 32'h0000_00A5, 1'b1, 1'b0};
    vecs[16] = '{3'b111, 32'h0000_04FF, 32'h0,         1'b1, 32'h0000_0000, 1'b1, 1'b1};
    vecs[17] = '{3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid[0] = 1'b0;  in_valid[1] = 1'b0;
    out_ready[0] = 1'b1; out_ready[1] = 1'b1;
    instruction = '0; imm_src = '0; rm_data = '0; carry_in = 1'b0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_p%0d_valid", k + 1), 32'(out_valid[k]), 32'd0);
      check($sformatf("rst_p%0d_data", k + 1),  out_data[k], 32'd0);
      check($sformatf("rst_p%0d_carry", k + 1), 32'(carry_out[k]), 32'd0);
      check($sformatf("rst_p%0d_err", k + 1),   32'(out_err[k]), 32'd0);
      check($sformatf("rst_p%0d_tag", k + 1),   32'(out_tag[k]), 32'd0);
      check($sformatf("rst_p%0d_ready", k + 1), 32'(in_ready[k]), 32'd1);
    end
    step();

    // Vector table: one op into both DUTs, then check exact latency.
    for (int i = 0; i < 18; i++) begin
      imm_src = vecs[i].src; instruction = vecs[i].instr;
      rm_data = vecs[i].rm;  carry_in = vecs[i].cin; in_tag = TAG_W'(i % 16);
      in_valid[0] = 1'b1; in_valid[1] = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_p1_in_ready", i), 32'(in_ready[0]), 32'd1);
      check($sformatf("v%0d_p2_in_ready", i), 32'(in_ready[1]), 32'd1);
      step();
      in_valid[0] = 1'b0; in_valid[1] = 1'b0;
      @(negedge clk);
      check_result(0, i);
      check($sformatf("v%0d_p2_early", i), 32'(out_valid[1]), 32'd0);
      step();
      @(negedge clk);
      check_result(1, i);
      check($sformatf("v%0d_p1_drained", i), 32'(out_valid[0]), 32'd0);
      step();
    end

    stall_test(0);
    stall_test(1);

    // Reset with operations in flight.
    imm_src = IMM_LS12; instruction = 32'h555;
    in_valid[0] = 1'b1; in_valid[1] = 1'b1;
    out_ready[0] = 1'b0; out_ready[1] = 1'b0;
    in_tag = 4'd5; step();
    in_tag = 4'd6; step();
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    rst = 1'b1;
    step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("midrst_p%0d_valid", k + 1), 32'(out_valid[k]), 32'd0);
      check($sformatf("midrst_p%0d_tag", k + 1),   32'(out_tag[k]), 32'd0);
    end
    rst = 1'b0;
    out_ready[0] = 1'b1; out_ready[1] = 1'b1;
    stale[0] = 0; stale[1] = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) if (out_valid[k]) stale[k]++;
      step();
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("midrst_p%0d_stale", k + 1), 32'(stale[k]), 32'd0);
      check($sformatf("midrst_p%0d_ready", k + 1), 32'(in_ready[k]), 32'd1);
    end

    // Back-to-back streaming of 8 ops at full rate.
    imm_src = IMM_LS12;
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; first[k] = -1; last[k] = -1; stall[k] = 0;
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid[0] = (cyc < 8); in_valid[1] = (cyc < 8);
      instruction = 32'(cyc); in_tag = TAG_W'(cyc);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (cyc < 8 && !in_ready[k]) stall[k]++;
        if (out_valid[k]) begin
          check($sformatf("stream_p%0d_data%0d", k + 1, cnt[k]), out_data[k], 32'(cnt[k]));
          check($sformatf("stream_p%0d_tag%0d", k + 1, cnt[k]), 32'(out_tag[k]), 32'(cnt[k] % 16));
          if (cnt[k] == 0) first[k] = cyc;
          last[k] = cyc;
          cnt[k]++;
        end
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      check($sformatf("stream_p%0d_count", k + 1),   32'(cnt[k]), 32'd8);
      check($sformatf("stream_p%0d_latency", k + 1), 32'(first[k]), 32'(k + 1));
      check($sformatf("stream_p%0d_span", k + 1),    32'(last[k] - first[k]), 32'd7);
      check($sformatf("stream_p%0d_stalls", k + 1),  32'(stall[k]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
